// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: controller state encoding,
// operand width and the multicycle counter sizing.
package multdiv_pkg;

    localparam int MULT_W               = 32;
    localparam int MULT_DEFAULT_LATENCY = 4;
    localparam int MULT_CNT_W           = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mult_state_e;

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_BUSY = BUSY;

endpackage

// File: rtl/mult_ctrl_booth.sv
// Combinational radix-4 Booth multiplier, 32x32 signed. Produces the low word
// of the product and a flag when the full product does not fit in 32 bits.
module mult_ctrl_booth
    import multdiv_pkg::*;
(
    input  logic [MULT_W-1:0] data_operandA,
    input  logic [MULT_W-1:0] data_operandB,
    output logic [MULT_W-1:0] mult_result,
    output logic              data_exception,
    output logic              data_resultRDY
);
    localparam int PP_N = MULT_W / 2;
    localparam int P_W  = 2 * MULT_W;

    logic [MULT_W:0]  b_ext;
    logic [P_W-1:0]   a_ext;
    logic [P_W-1:0]   pp [PP_N];
    logic [P_W-1:0]   sum;

    assign b_ext = {data_operandB, 1'b0};
    assign a_ext = {{MULT_W{data_operandA[MULT_W-1]}}, data_operandA};

    genvar gi;
    generate
        for (gi = 0; gi < PP_N; gi++) begin : g_pp
            logic [2:0]     sel;
            logic [P_W-1:0] mag;

            // Booth digit from bits {2i+1, 2i, 2i-1}; bit -1 is the appended zero
            assign sel = b_ext[2*gi+2 : 2*gi];

            always_comb begin
                case (sel)
                    3'b001, 3'b010: mag = a_ext;
                    3'b011:         mag = a_ext << 1;
                    3'b100:         mag = -(a_ext << 1);
                    3'b101, 3'b110: mag = -a_ext;
                    default:        mag = '0;
                endcase
            end

            assign pp[gi] = mag << (2 * gi);
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < PP_N; i++) begin
            sum = sum + pp[i];
        end
    end

    assign mult_result    = sum[MULT_W-1:0];
    // Fits in 32 signed bits only if the top 33 bits are all copies of the sign
    assign data_exception = ~((&sum[P_W-1:MULT_W-1]) | ~(|sum[P_W-1:MULT_W-1]));
    assign data_resultRDY = 1'b1;

endmodule

// File: rtl/mult_ctrl.sv
// Multicycle controller for the combinational Booth multiplier: latches operands,
// waits LATENCY edges, registers product/overflow and pulses data_resultRDY.
// Optional build macro MULT_ZERO_BYPASS_EN: a zero operand completes after one edge.
module mult_ctrl
    import multdiv_pkg::*;
#(
    parameter int LATENCY = MULT_DEFAULT_LATENCY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_MULT,
    input  logic [MULT_W-1:0] data_operandA,
    input  logic [MULT_W-1:0] data_operandB,
    output logic [MULT_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);
    localparam logic [MULT_CNT_W-1:0] CNT_LOAD = MULT_CNT_W'(LATENCY - 1);

    logic [0:0]            state_reg,  state_next;
    logic [MULT_CNT_W-1:0] cnt_reg,    cnt_next;
    logic [MULT_W-1:0]     opA_q,      opA_next;
    logic [MULT_W-1:0]     opB_q,      opB_next;
    logic [MULT_W-1:0]     result_reg, result_next;
    logic                  exc_reg,    exc_next;
    logic                  rdy_reg,    rdy_next;

    logic [MULT_W-1:0]     mult_result;
    logic                  mult_exception;
    logic                  mult_rdy_unused;

`ifdef MULT_ZERO_BYPASS_EN
    logic operand_zero;
    assign operand_zero = ~(|data_operandA) | ~(|data_operandB);
`endif

    // The array only ever sees the held operands, so it settles undisturbed
    mult_ctrl_booth u_booth (
        .data_operandA  (opA_q),
        .data_operandB  (opB_q),
        .mult_result    (mult_result),
        .data_exception (mult_exception),
        .data_resultRDY (mult_rdy_unused)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        opA_next    = opA_q;
        opB_next    = opB_q;
        result_next = result_reg;
        exc_next    = exc_reg;
        rdy_next    = 1'b0;

        if (ctrl_MULT) begin
            // A request in any state (re)starts; an in-flight result is dropped
            opA_next = data_operandA;
            opB_next = data_operandB;
`ifdef MULT_ZERO_BYPASS_EN
            if (operand_zero) begin
                state_next  = ST_IDLE;
                cnt_next    = '0;
                result_next = '0;
                exc_next    = 1'b0;
                rdy_next    = 1'b1;
            end else begin
                state_next = ST_BUSY;
                cnt_next   = CNT_LOAD;
            end
`else
            state_next = ST_BUSY;
            cnt_next   = CNT_LOAD;
`endif
        end else if (state_reg == ST_BUSY) begin
            if (cnt_reg != '0) begin
                cnt_next = cnt_reg - 1'b1;
            end else begin
                state_next  = ST_IDLE;
                result_next = mult_result;
                exc_next    = mult_exception;
                rdy_next    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            result_reg <= '0;
            exc_reg    <= 1'b0;
            rdy_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            opA_q      <= opA_next;
            opB_q      <= opB_next;
            result_reg <= result_next;
            exc_reg    <= exc_next;
            rdy_reg    <= rdy_next;
        end
    end

    assign data_result    = result_reg;
    assign data_exception = exc_reg;
    assign data_resultRDY = rdy_reg;
    assign busy           = (state_reg == ST_BUSY);

endmodule
